// File: rtl/phase_sequencer.sv
// Round-robin phase sequencer: enables one engine phase at a time, ends each phase
// on its done pulse or a watchdog expiry, and counts completed frames.
module phase_sequencer #(
  parameter int NUM_PHASES = 2,
  parameter int TIMEOUT_W  = 16,
  parameter int FRAME_W    = 16,
  parameter int IDX_W      = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [NUM_PHASES-1:0] phase_mask,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [IDX_W-1:0]      active_phase,
  output logic                  busy,
  output logic                  frame_tick,
  output logic [FRAME_W-1:0]    frame_count,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      timeout_phase
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t                  state_q;
  logic                    last_q;
  logic [TIMEOUT_W-1:0]    wdog_q;
  logic [NUM_PHASES-1:0]   phase_en_q;
  logic [IDX_W-1:0]        active_q;
  logic                    busy_q;
  logic                    frame_tick_q;
  logic [FRAME_W-1:0]      frame_count_q;
  logic                    timeout_err_q;
  logic [IDX_W-1:0]        timeout_phase_q;

  function automatic logic has_from(input logic [NUM_PHASES-1:0] m, input int lo);
    has_from = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++)
      if (i >= lo && m[i]) has_from = 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_from(input logic [NUM_PHASES-1:0] m, input int lo);
    idx_from = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (i >= lo && m[i]) idx_from = IDX_W'(i);
  endfunction

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_PHASES'(1) << idx;
  endfunction

  logic             done_hit;
  logic             wd_hit;
  logic             more_above;
  logic             mask_any;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] low_idx;

  assign done_hit   = phase_done[active_q];
  assign wd_hit     = (timeout_limit != '0) && (wdog_q == timeout_limit - TIMEOUT_W'(1));
  assign more_above = has_from(phase_mask, int'(active_q) + 1);
  assign next_idx   = idx_from(phase_mask, int'(active_q) + 1);
  assign low_idx    = idx_from(phase_mask, 0);
  assign mask_any   = |phase_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      last_q          <= 1'b0;
      wdog_q          <= '0;
      phase_en_q      <= '0;
      active_q        <= '0;
      busy_q          <= 1'b0;
      frame_tick_q    <= 1'b0;
      frame_count_q   <= '0;
      timeout_err_q   <= 1'b0;
      timeout_phase_q <= '0;
    end else begin
      frame_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run && mask_any) begin
            state_q    <= S_RUN;
            active_q   <= low_idx;
            phase_en_q <= onehot(low_idx);
            wdog_q     <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (done_hit || wd_hit) begin
            state_q    <= S_GAP;
            phase_en_q <= '0;
            // Done wins over a coincident watchdog expiry.
            if (!done_hit) begin
              timeout_err_q   <= 1'b1;
              timeout_phase_q <= active_q;
            end
            last_q <= !more_above;
            if (!more_above) begin
              frame_tick_q  <= 1'b1;
              frame_count_q <= frame_count_q + FRAME_W'(1);
            end
          end else begin
            wdog_q <= wdog_q + TIMEOUT_W'(1);
          end
        end
        S_GAP: begin
          // A frame already ticked restarts only under run; otherwise continue upward.
          if (!last_q && more_above) begin
            state_q    <= S_RUN;
            active_q   <= next_idx;
            phase_en_q <= onehot(next_idx);
            wdog_q     <= '0;
          end else if (last_q && run && mask_any) begin
            state_q    <= S_RUN;
            active_q   <= low_idx;
            phase_en_q <= onehot(low_idx);
            wdog_q     <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          phase_en_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign phase_en      = phase_en_q;
  assign active_phase  = active_q;
  assign busy          = busy_q;
  assign frame_tick    = frame_tick_q;
  assign frame_count   = frame_count_q;
  assign timeout_err   = timeout_err_q;
  assign timeout_phase = timeout_phase_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer: the bench plays the engines and predicts
// every output from a phase-level reference model.
module tb_phase_sequencer;
  localparam int NP = 4;
  localparam int TW = 8;
  localparam int FW = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic [NP-1:0] phase_mask = '0;
  logic [NP-1:0] phase_done = '0;
  logic [TW-1:0] timeout_limit = '0;
  logic [NP-1:0] phase_en;
  logic [IW-1:0] active_phase;
  logic          busy;
  logic          frame_tick;
  logic [FW-1:0] frame_count;
  logic          timeout_err;
  logic [IW-1:0] timeout_phase;

  phase_sequencer #(.NUM_PHASES(NP), .TIMEOUT_W(TW), .FRAME_W(FW), .IDX_W(IW)) dut (
    .clk(clk), .resetn(resetn), .run(run), .phase_mask(phase_mask),
    .phase_done(phase_done), .timeout_limit(timeout_limit), .phase_en(phase_en),
    .active_phase(active_phase), .busy(busy), .frame_tick(frame_tick),
    .frame_count(frame_count), .timeout_err(timeout_err), .timeout_phase(timeout_phase)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase is enabled and for how many cycles so far.
  int m_phase, m_act, m_cnt, m_tgt, m_frames, m_tph;
  bit m_gap, m_complete, m_busy, m_tick, m_err;

  function automatic int first_from(input logic [NP-1:0] m, input int lo);
    for (int i = lo; i < NP; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = -1; m_act = 0; m_cnt = 0; m_tgt = 0; m_frames = 0; m_tph = 0;
    m_gap = 0; m_complete = 0; m_busy = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic start_phase(input int p);
    m_phase = p; m_act = p; m_cnt = 1; m_busy = 1;
    if (timeout_limit != 0 && $urandom_range(0, 3) == 0) m_tgt = 0;
    else m_tgt = int'($urandom_range(1, 7));
  endtask

  task automatic model_edge();
    int nxt;
    bit done, to;
    m_tick = 0;
    if (m_phase >= 0) begin
      done = phase_done[m_phase];
      to = (timeout_limit != 0) && (m_cnt == int'(timeout_limit));
      if (done || to) begin
        if (!done) begin m_err = 1; m_tph = m_phase; end
        nxt = first_from(phase_mask, m_phase + 1);
        m_complete = (nxt < 0);
        if (m_complete) begin m_tick = 1; m_frames = (m_frames + 1) % 4; end
        m_phase = -1;
        m_gap = 1;
      end else m_cnt++;
    end else if (m_gap) begin
      m_gap = 0;
      nxt = first_from(phase_mask, m_act + 1);
      if (!m_complete && nxt >= 0) start_phase(nxt);
      else if (m_complete && run && phase_mask != 0) start_phase(first_from(phase_mask, 0));
      else m_busy = 0;
    end else if (run && phase_mask != 0) begin
      start_phase(first_from(phase_mask, 0));
    end
  endtask

  task automatic check_all();
    check("phase_en", 32'(phase_en), (m_phase >= 0) ? (32'd1 << m_phase) : 32'd0);
    check("active_phase", 32'(active_phase), 32'(m_act));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("frame_count", 32'(frame_count), 32'(m_frames));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("timeout_phase", 32'(timeout_phase), 32'(m_tph));
  endtask

  task automatic cycle();
    logic [NP-1:0] pd;
    @(negedge clk);
    check_all();
    if (m_phase < 0 && !m_gap) begin
      if ($urandom_range(0, 9) == 0) phase_mask = NP'($urandom);
      if ($urandom_range(0, 9) == 0)
        timeout_limit = ($urandom_range(0, 1) == 1) ? '0 : TW'($urandom_range(1, 6));
    end
    if ($urandom_range(0, 24) == 0) run = ~run;
    pd = NP'($urandom);
    if (m_phase >= 0) pd[m_phase] = (m_cnt == m_tgt);
    phase_done = pd;
    model_edge();
  endtask

  initial begin
    bit reached;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    model_edge();

    for (int c = 0; c < 1500; c++) cycle();

    // Asynchronous reset while a phase is enabled.
    reached = 0;
    for (int c = 0; c < 300 && !reached; c++) begin
      run = 1'b1;
      if (phase_mask == 0) phase_mask = 4'b0011;
      cycle();
      if (m_phase >= 0) reached = 1;
    end
    check("reach_run", 32'(reached), 32'd1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    run = 1'b0;
    phase_done = '0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    model_edge();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all();
      model_edge();
    end

    for (int c = 0; c < 2500; c++) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
